// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the snapshot memory bridge stages.
package mem_bridge_pkg;

  // One-hot bridge controller states.
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_ISSUE   = 5'b00010,
    S_RD_WAIT = 5'b00100,
    S_ACK     = 5'b01000,
    S_DROP    = 5'b10000
  } state_e;

  // Request operation decoded from the wr/rd enables.
  typedef enum logic [1:0] {
    OP_RD      = 2'd0,
    OP_WR      = 2'd1,
    OP_ILLEGAL = 2'd2
  } mem_op_e;

  // Exactly one of the enables must be set for a usable operation.
  function automatic mem_op_e f_decode_op(input logic wr_en, input logic rd_en);
    mem_op_e op;
    op = OP_ILLEGAL;
    if (wr_en && !rd_en) op = OP_WR;
    if (rd_en && !wr_en) op = OP_RD;
    return op;
  endfunction

  // Ceiling log2, used to size counters at elaboration time.
  function automatic int f_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_sram_bridge.sv
// Bridge from the level-held memory request interface to a single-port
// synchronous SRAM with fixed read latency. One SRAM access per legal
// request, one-cycle ack; illegal requests are acked with an error flag.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for mem_req_vld; request latched and checked here
// S_ISSUE   | sram_cs high for this single cycle
// S_RD_WAIT | counting down the SRAM read latency, then capture rdata
// S_ACK     | mem_ack_vld high with rd data / error flag
// S_DROP    | waiting for upstream to release mem_req_vld
module mem_sram_bridge
  import mem_bridge_pkg::*;
#(
  parameter int MEM_DATA_WIDTH  = 64,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int SRAM_DEPTH      = 1024,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       soft_rst,
  input  logic                       mem_req_vld,
  output logic                       mem_ack_vld,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  input  logic                       mem_wr_en,
  input  logic                       mem_rd_en,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_wr_data,
  output logic [MEM_DATA_WIDTH-1:0]  mem_rd_data,
  output logic                       mem_err,
  output logic                       sram_cs,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0]  sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]  sram_rdata
);

  localparam int CNT_W = f_log2(RD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  state_e                      r_state;
  state_e                      w_state_nxt;
  mem_op_e                     r_op;
  mem_op_e                     w_op_in;
  logic                        r_err;
  logic [MEM_DATA_WIDTH-1:0]   r_rd;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_sram_cs;
  logic                        r_sram_we;
  logic [SRAM_ADDR_WIDTH-1:0]  r_sram_addr;
  logic [MEM_DATA_WIDTH-1:0]   r_sram_wdata;
  logic                        w_in_range;
  logic                        w_legal;
  logic                        w_accept;

  // Request decode and next-state selection.
  always_comb begin
    w_op_in     = f_decode_op(mem_wr_en, mem_rd_en);
    w_in_range  = ({1'b0, mem_addr} < (MEM_ADDR_WIDTH + 1)'(SRAM_DEPTH));
    w_legal     = (w_op_in != OP_ILLEGAL) && w_in_range;
    w_accept    = (r_state == S_IDLE) && mem_req_vld;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (mem_req_vld) w_state_nxt = w_legal ? S_ISSUE : S_ACK;
      S_ISSUE:   w_state_nxt = (r_op == OP_WR) ? S_ACK : S_RD_WAIT;
      S_RD_WAIT: if (r_cnt == '0) w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_DROP;
      S_DROP:    if (!mem_req_vld) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register; soft reset wins over any request presented with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_state <= S_IDLE;
    else if (soft_rst) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Request latch, SRAM output registers, latency counter and read capture.
  // The SRAM registers are loaded on acceptance so sram_cs lines up with S_ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_RD;
      r_err        <= 1'b0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_sram_cs    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else if (soft_rst) begin
      r_op         <= OP_RD;
      r_err        <= 1'b0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_sram_cs    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_sram_cs    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      if (w_accept) begin
        r_op  <= w_op_in;
        r_err <= !w_legal;
        r_rd  <= '0;
        if (w_legal) begin
          r_sram_cs   <= 1'b1;
          r_sram_we   <= (w_op_in == OP_WR);
          r_sram_addr <= mem_addr[SRAM_ADDR_WIDTH-1:0];
          if (w_op_in == OP_WR) r_sram_wdata <= mem_wr_data;
        end
      end
      if ((r_state == S_ISSUE) && (r_op == OP_RD)) r_cnt <= CNT_LOAD;
      if (r_state == S_RD_WAIT) begin
        if (r_cnt == '0) r_rd  <= sram_rdata;
        else             r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // r_rd is cleared on acceptance and only loaded by a legal read.
  assign mem_ack_vld = (r_state == S_ACK);
  assign mem_err     = mem_ack_vld & r_err;
  assign mem_rd_data = mem_ack_vld ? r_rd : '0;

  assign sram_cs     = r_sram_cs;
  assign sram_we     = r_sram_we;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Self-checking bench for mem_sram_bridge with a latency-3 SRAM model.
module tb_mem_sram_bridge;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int SAW   = 10;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic           clk         = 1'b0;
  logic           rst_n       = 1'b0;
  logic           soft_rst    = 1'b0;
  logic           mem_req_vld = 1'b0;
  logic           mem_wr_en   = 1'b0;
  logic           mem_rd_en   = 1'b0;
  logic [AW-1:0]  mem_addr    = '0;
  logic [DW-1:0]  mem_wr_data = '0;
  logic           mem_ack_vld;
  logic           mem_err;
  logic           sram_cs;
  logic           sram_we;
  logic [DW-1:0]  mem_rd_data;
  logic [DW-1:0]  sram_wdata;
  logic [DW-1:0]  sram_rdata;
  logic [SAW-1:0] sram_addr;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sram_arr [DEPTH];
  logic [DW-1:0] rd_pipe  [LAT];
  logic [DW-1:0] ref_mem  [DEPTH];
  bit            written  [DEPTH];

  always #5 clk = ~clk;

  mem_sram_bridge #(
    .MEM_DATA_WIDTH (DW),
    .MEM_ADDR_WIDTH (AW),
    .SRAM_ADDR_WIDTH(SAW),
    .SRAM_DEPTH     (DEPTH),
    .RD_LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_rst   (soft_rst),
    .mem_req_vld(mem_req_vld),
    .mem_ack_vld(mem_ack_vld),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .mem_err    (mem_err),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM macro model: synchronous write, read data after LAT clocks, noise otherwise.
  always @(posedge clk) begin
    if (sram_cs && sram_we) sram_arr[sram_addr] <= sram_wdata;
    if (sram_cs && !sram_we) rd_pipe[0] <= sram_arr[sram_addr];
    else                     rd_pipe[0] <= {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, hold it `hold` cycles past the ack, and check the
  // whole transaction against the bench's own timing/data expectations.
  task automatic run_txn(input string tag, input logic [AW-1:0] a, input logic wr,
                         input logic rd, input logic [DW-1:0] d, input int hold);
    logic           legal;
    int             exp_ack;
    logic [DW-1:0]  exp_rd;
    int             ack_n, ack_k, cs_n, cs_k;
    logic [SAW-1:0] cs_a;
    logic           cs_we;
    logic [DW-1:0]  cs_d;
    logic [DW-1:0]  got_rd;
    logic           got_err;
    logic           dirty;
    legal   = (wr != rd) && (a < AW'(DEPTH));
    exp_ack = !legal ? 1 : (wr ? 2 : 2 + LAT);
    exp_rd  = (legal && rd) ? ref_mem[a[SAW-1:0]] : '0;
    ack_n = 0; ack_k = -1; cs_n = 0; cs_k = -1;
    cs_a = '0; cs_we = 1'b0; cs_d = '0; got_rd = '0; got_err = 1'b0; dirty = 1'b0;
    mem_addr    = a;
    mem_wr_en   = wr;
    mem_rd_en   = rd;
    mem_wr_data = d;
    mem_req_vld = 1'b1;
    for (int k = 1; k <= 40 + hold; k++) begin
      @(posedge clk); #1;
      if (mem_ack_vld) begin
        ack_n++;
        if (ack_k < 0) begin ack_k = k; got_rd = mem_rd_data; got_err = mem_err; end
      end else if (mem_rd_data !== '0 || mem_err !== 1'b0) dirty = 1'b1;
      if (sram_cs) begin
        cs_n++;
        if (cs_k < 0) begin cs_k = k; cs_a = sram_addr; cs_we = sram_we; cs_d = sram_wdata; end
      end else if (sram_we !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0) dirty = 1'b1;
      if (ack_k >= 0 && k >= ack_k + hold) mem_req_vld = 1'b0;
      if (mem_req_vld) begin
        // Upstream churn while a transaction is in flight must be ignored.
        mem_addr    = $urandom;
        mem_wr_data = {$urandom, $urandom};
        mem_wr_en   = 1'($urandom_range(0, 1));
        mem_rd_en   = 1'($urandom_range(0, 1));
      end
      if (ack_k >= 0 && k >= ack_k + hold + 3) break;
    end
    mem_req_vld = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    if (legal && wr) begin
      ref_mem[a[SAW-1:0]] = d;
      written[a[SAW-1:0]] = 1'b1;
    end
    chk({tag, ".ack_cycle"}, 64'(ack_k), 64'(exp_ack));
    chk({tag, ".ack_count"}, 64'(ack_n), 64'd1);
    chk({tag, ".err"}, 64'(got_err), 64'(!legal));
    chk({tag, ".rd_data"}, got_rd, exp_rd);
    chk({tag, ".cs_count"}, 64'(cs_n), 64'(legal));
    chk({tag, ".idle_zero"}, 64'(dirty), 64'd0);
    if (legal) begin
      chk({tag, ".cs_cycle"}, 64'(cs_k), 64'd1);
      chk({tag, ".cs_addr"}, 64'(cs_a), 64'(a[SAW-1:0]));
      chk({tag, ".cs_we"}, 64'(cs_we), 64'(wr));
      if (wr) chk({tag, ".cs_wdata"}, cs_d, d);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctl", 64'({mem_ack_vld, mem_err, sram_cs, sram_we, sram_addr}), 64'd0);
    chk("reset.rd_data", mem_rd_data, 64'd0);
    chk("reset.wdata", sram_wdata, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("wr5",        AW'(5),         1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, 0);
    run_txn("rd5",        AW'(5),         1'b0, 1'b1, 64'd0, 0);
    run_txn("err_both",   AW'(5),         1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 0);
    run_txn("err_oob_wr", AW'(DEPTH),     1'b1, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 0);
    run_txn("err_oob_rd", AW'(DEPTH),     1'b0, 1'b1, 64'd0, 0);
    run_txn("err_none",   AW'(5),         1'b0, 1'b0, 64'd0, 0);
    run_txn("wr_last",    AW'(DEPTH - 1), 1'b1, 1'b0, 64'hA5A5_5A5A_0000_FFFF, 0);
    run_txn("rd_last",    AW'(DEPTH - 1), 1'b0, 1'b1, 64'd0, 0);
    run_txn("rd5_again",  AW'(5),         1'b0, 1'b1, 64'd0, 0);
    run_txn("hold6_wr",   AW'(9),         1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 6);
    run_txn("hold6_rd",   AW'(9),         1'b0, 1'b1, 64'd0, 6);
    run_txn("after_hold", AW'(9),         1'b0, 1'b1, 64'd0, 0);

    // Soft reset while waiting on read latency: no ack, outputs cleared.
    mem_addr = AW'(5); mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_req_vld = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    soft_rst = 1'b1; mem_req_vld = 1'b0; mem_rd_en = 1'b0;
    @(posedge clk); #1;
    soft_rst = 1'b0;
    chk("srst.ctl", 64'({mem_ack_vld, mem_err, sram_cs, sram_we, sram_addr}), 64'd0);
    chk("srst.rd_data", mem_rd_data, 64'd0);
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_ack_vld || sram_cs) n++;
    end
    chk("srst.no_activity", 64'(n), 64'd0);
    run_txn("srst_rd5", AW'(5), 1'b0, 1'b1, 64'd0, 0);

    // Request presented together with soft reset is dropped.
    soft_rst = 1'b1; mem_req_vld = 1'b1; mem_wr_en = 1'b1; mem_addr = AW'(5);
    mem_wr_data = {$urandom, $urandom};
    @(posedge clk); #1;
    soft_rst = 1'b0; mem_req_vld = 1'b0; mem_wr_en = 1'b0;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ack_vld || sram_cs) n++;
    end
    chk("srst_req.no_activity", 64'(n), 64'd0);
    run_txn("srst_req_rd5", AW'(5), 1'b0, 1'b1, 64'd0, 0);

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic          wr;
      logic          rd;
      int            sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       a = AW'($urandom_range(0, 7));
      else if (sel < 8)  a = AW'(DEPTH - 8 + int'($urandom_range(0, 7)));
      else if (sel == 8) a = AW'(DEPTH + int'($urandom_range(0, 3)));
      else               a = $urandom | 32'h0000_0400;
      sel = int'($urandom_range(0, 9));
      wr = (sel < 4) || (sel == 8);
      rd = ((sel >= 4) && (sel < 8)) || (sel == 8);
      if (rd && !wr && (a < AW'(DEPTH)) && !written[a[SAW-1:0]]) begin
        wr = 1'b1;
        rd = 1'b0;
      end
      run_txn($sformatf("rnd%0d", t), a, wr, rd, {$urandom, $urandom},
              int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
